setup_multi: RTL

Parametrised time-setting controller for the clock display path. When the mode input selects setup, it captures the running time, lets the user step through N fields with select/up/down/confirm buttons, wrap-limits each field to its own maximum, and emits a one-cycle load pulse with the edited value for the timekeeping counter. Buttons are sampled on the system clock; nothing is clocked by a button.

---
 rtl/setup_multi.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/setup_multi.sv
// Time-setting controller: captures running time, edits N wrap-limited fields, strobes the result.
// Optional build macro SETUP_AUTOREPEAT_EN adds hold-to-repeat on the up/down buttons.
module setup_multi #(
    parameter int                           FIELDS     = 3,
    parameter int                           FIELD_W    = 8,
    parameter logic [FIELDS*FIELD_W-1:0]    FIELD_MAX  = {8'd23, 8'd59, 8'd59},
    parameter logic [1:0]                   SETUP_MODE = 2'd3,
    parameter int                           TIMEOUT    = 30_000_000,
    parameter int                           REPEAT_DLY = 12_000_000,
    parameter int                           REPEAT_PER = 3_000_000,
    localparam int                          FI_W       = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [FIELDS*FIELD_W-1:0]   data_ch,
    input  logic [0:3]                  button,
    input  logic [1:0]                  rezhim,
    output logic [FIELDS*FIELD_W-1:0]   setup_data,
    output logic                        setup_imp,
    output logic [FI_W-1:0]             setup_field,
    output logic                        setup_active,
    output logic [1:0]                  o_dbg_state
);

    localparam int DW   = FIELDS * FIELD_W;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EDIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [0:3]         r_b1, r_b2;
    logic [0:3]         w_press;
    logic [DW-1:0]      r_data, w_data_nxt, w_data_step;
    logic [FI_W-1:0]    r_field, w_field_nxt;
    logic               r_imp, w_imp_nxt;
    logic [TO_W-1:0]    r_to, w_to_nxt;
    logic [FIELD_W-1:0] w_cur, w_max, w_inc_val, w_dec_val, w_new_val;
    logic               w_up, w_dn, w_any, w_timeout;
    logic               w_rep_up, w_rep_dn;

    // Button bit order: [0] down, [1] up, [2] select, [3] confirm.
    assign w_press   = r_b1 & ~r_b2;
    assign w_up      = w_press[1] | w_rep_up;
    assign w_dn      = w_press[0] | w_rep_dn;
    assign w_any     = (|w_press) | w_rep_up | w_rep_dn;
    assign w_timeout = ~w_any && (r_to == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_cur = '0;
        w_max = '0;
        for (int f = 0; f < FIELDS; f++) begin
            if (r_field == FI_W'(f)) begin
                w_cur = r_data[f*FIELD_W +: FIELD_W];
                w_max = FIELD_MAX[f*FIELD_W +: FIELD_W];
            end
        end
    end

    // Out-of-range captured values wrap to 0 going up and clamp to max going down.
    assign w_inc_val = (w_cur >= w_max) ? '0 : w_cur + FIELD_W'(1);
    assign w_dec_val = ((w_cur == '0) || (w_cur > w_max)) ? w_max : w_cur - FIELD_W'(1);
    assign w_new_val = w_up ? w_inc_val : w_dec_val;

    always_comb begin
        w_data_step = r_data;
        for (int f = 0; f < FIELDS; f++) begin
            if (r_field == FI_W'(f)) begin
                w_data_step[f*FIELD_W +: FIELD_W] = w_new_val;
            end
        end
    end

    // setup_imp is a one-cycle push with no back-pressure: the consumer must take setup_data
    // in the cycle setup_imp is high; setup_data then stays stable until the next capture.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_field_nxt = r_field;
        w_imp_nxt   = 1'b0;
        w_to_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (rezhim == SETUP_MODE) begin
                    w_state_nxt = S_EDIT;
                    w_data_nxt  = data_ch;
                    w_field_nxt = '0;
                end
            end
            S_EDIT: begin
                if (rezhim != SETUP_MODE) begin
                    w_state_nxt = S_IDLE;
                end else if (w_press[3]) begin
                    w_imp_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_to_nxt = w_any ? '0 : r_to + TO_W'(1);
                    if (w_press[2]) begin
                        w_field_nxt = (r_field == FI_W'(FIELDS - 1)) ? '0 : r_field + FI_W'(1);
                    end else if (w_up ^ w_dn) begin
                        w_data_nxt = w_data_step;
                    end
                end
            end
            S_DONE: begin
                if (rezhim != SETUP_MODE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_b1    <= '0;
            r_b2    <= '0;
            r_data  <= '0;
            r_field <= '0;
            r_imp   <= 1'b0;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_b1    <= button;
            r_b2    <= r_b1;
            r_data  <= w_data_nxt;
            r_field <= w_field_nxt;
            r_imp   <= w_imp_nxt;
            r_to    <= w_to_nxt;
        end
    end

`ifdef SETUP_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] r_rep_cnt;
    logic            r_rep_on, r_rep_dir, r_rep_phase;
    logic            w_held, w_rep_hit;

    // r_rep_dir: 1 = up, 0 = down. Holding the opposite button too cancels the repeat.
    assign w_held    = r_rep_dir ? (r_b2[1] & ~r_b2[0]) : (r_b2[0] & ~r_b2[1]);
    assign w_rep_hit = r_rep_on & w_held &
                       (r_rep_cnt == (r_rep_phase ? RP_W'(REPEAT_PER) : RP_W'(REPEAT_DLY)));
    assign w_rep_up  = w_rep_hit & r_rep_dir;
    assign w_rep_dn  = w_rep_hit & ~r_rep_dir;

    always_ff @(posedge clock) begin
        if (reset || (r_state != S_EDIT)) begin
            r_rep_on    <= 1'b0;
            r_rep_dir   <= 1'b0;
            r_rep_phase <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (w_press[1] ^ w_press[0]) begin
            r_rep_on    <= 1'b1;
            r_rep_dir   <= w_press[1];
            r_rep_phase <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (r_rep_on && w_held) begin
            if (w_rep_hit) begin
                r_rep_phase <= 1'b1;
                r_rep_cnt   <= RP_W'(1);
            end else begin
                r_rep_cnt   <= r_rep_cnt + RP_W'(1);
            end
        end else begin
            r_rep_on    <= 1'b0;
            r_rep_phase <= 1'b0;
            r_rep_cnt   <= '0;
        end
    end
`else
    assign w_rep_up = 1'b0;
    assign w_rep_dn = 1'b0;
`endif

    assign setup_data   = r_data;
    assign setup_imp    = r_imp;
    assign setup_field  = r_field;
    assign setup_active = (r_state == S_EDIT);
    assign o_dbg_state  = r_state;

endmodule
